// File: rtl/tff_pkg.sv
// Shared direction constants and operation decode for the toggle-cell counter.
// No state; no flow control.
package tff_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_LOAD,
        CNT_STEP
    } cnt_op_e;

    // Reset is handled inside each cell, so only load vs. enable is decoded here.
    function automatic cnt_op_e cnt_decode(input logic load, input logic en);
        if (load) begin
            return CNT_LOAD;
        end
        if (en) begin
            return CNT_STEP;
        end
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// One-bit toggle cell with synchronous reset and parallel load; q and qb registered.
// Latency one clock; no backpressure.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic ld_val,
    input  logic t,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else if (ld) begin
            q  <= ld_val;
            qb <= ~ld_val;
        end else begin
            q  <= q ^ t;
            qb <= ~(q ^ t);
        end
    end

endmodule

// File: rtl/tff_sync_counter.sv
// WIDTH-bit up/down counter from a chain of toggle cells; tc carries into the next stage.
// Latency one clock for q/qb, tc combinational; no backpressure.
module tff_sync_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    cnt_op_e          op;
    logic             ld;
    logic             step;
    logic [WIDTH-1:0] lo_ones;
    logic [WIDTH-1:0] lo_zeros;
    logic [WIDTH-1:0] t;

    // lo_ones[i] / lo_zeros[i]: every bit below i is 1 / 0.
    always_comb begin
        op          = cnt_decode(load, en);
        ld          = (op == CNT_LOAD);
        step        = (op == CNT_STEP);
        lo_ones     = '0;
        lo_zeros    = '0;
        lo_ones[0]  = 1'b1;
        lo_zeros[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            lo_ones[i]  = lo_ones[i-1] & q[i-1];
            lo_zeros[i] = lo_zeros[i-1] & ~q[i-1];
        end
        t  = step ? ((up == DIR_UP) ? lo_ones : lo_zeros) : '0;
        tc = step & ~rst & ((up == DIR_DOWN) ? ~(|q) : (&q));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .ld     (ld),
            .ld_val (d[i]),
            .t      (t[i]),
            .q      (q[i]),
            .qb     (qb[i])
        );
    end

endmodule

// File: tb/tb_tff_sync_counter.sv
// Directed and random checks of tff_sync_counter against a modular-arithmetic reference.
module tb_tff_sync_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] d;
    logic [3:0] q, qb;
    logic       tc;

    logic       c_rst, c_en;
    logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
    logic       lo_tc, hi_tc;

    int vectors     = 0;
    int miscompares = 0;
    int mq          = 0;
    int cref        = 0;

    always #5 clk = ~clk;

    tff_sync_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .q(q), .qb(qb), .tc(tc)
    );

    tff_sync_counter #(.WIDTH(4)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0), .d(4'h0),
        .q(lo_q), .qb(lo_qb), .tc(lo_tc)
    );

    tff_sync_counter #(.WIDTH(4)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .up(1'b1), .load(1'b0), .d(4'h0),
        .q(hi_q), .qb(hi_qb), .tc(hi_tc)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge's worth of inputs, check tc before the edge and q/qb after it.
    task automatic cycle(input logic r, input logic l, input logic e, input logic u,
                         input logic [3:0] dv, input string tag);
        logic exp_tc;
        rst = r; load = l; en = e; up = u; d = dv;
        #1;
        exp_tc = !r && !l && e && (u ? (mq == 15) : (mq == 0));
        chk({tag, ".tc"}, {7'd0, tc}, {7'd0, exp_tc});
        @(posedge clk);
        #1;
        if (r)      mq = 0;
        else if (l) mq = int'(dv);
        else if (e) mq = u ? (mq + 1) % 16 : (mq + 15) % 16;
        chk({tag, ".q"},  {4'd0, q},  8'(mq));
        chk({tag, ".qb"}, {4'd0, qb}, 8'(15 - mq));
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; d = 4'h0;
        c_rst = 1'b1; c_en = 1'b0;

        // Reset dominates load and enable
        for (int i = 0; i < 2; i++) cycle(1, 1, 1, 1, 4'hA, "reset");

        // Full up run with wrap
        for (int i = 0; i < 17; i++) cycle(0, 0, 1, 1, 4'h0, "up_run");

        // Load then count down through zero
        cycle(0, 1, 1, 1, 4'h3, "load3");
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 4'h0, "down_run");

        // Direction flip each edge
        cycle(0, 1, 0, 1, 4'h7, "load7");
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, ((i % 2) == 0), 4'h0, "dir_flip");

        // Hold with direction toggling, then reset mid-run
        cycle(0, 1, 0, 0, 4'h5, "load5");
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, i[0], 4'h0, "hold");
        cycle(0, 0, 1, 1, 4'h0, "run_pre");
        cycle(0, 0, 1, 1, 4'h0, "run_pre");
        cycle(1, 0, 1, 1, 4'h0, "run_rst");
        cycle(0, 0, 1, 1, 4'h0, "run_post");
        cycle(0, 0, 1, 1, 4'h0, "run_post");

        // Random mix of reset, load, enable and direction
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), 4'($urandom), "random");
        end

        // Cascade: two 4-bit stages as one 8-bit counter
        @(posedge clk);
        #1;
        c_rst = 1'b0; c_en = 1'b1; cref = 0;
        chk("casc.reset", {hi_q, lo_q}, 8'h00);
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            cref = (cref + 1) % 256;
            chk("casc.q",  {hi_q, lo_q},   8'(cref));
            chk("casc.qb", {hi_qb, lo_qb}, 8'(255 - cref));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
